// File: rtl/m16_frame_sequencer.sv
// m16_frame_sequencer: fetches M16 filler words and serialises them MSB-first with frame/group markers
module m16_frame_sequencer #(
    parameter int CLK_PER_BIT     = 4,
    parameter int WORDS_PER_FRAME = 2048,
    parameter int GROUPS          = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [11:0] dataWord,
    output logic        bufGetWord,
    output logic [10:0] bufRdPointer,
    output logic [4:0]  cntGrp,
    output logic        serOut,
    output logic        bitStrobe,
    output logic        frameStart,
    output logic        groupStart,
    output logic        busy
);
    localparam logic [7:0]  DIV_MAX = 8'(CLK_PER_BIT - 1);
    localparam logic [10:0] PTR_MAX = 11'(WORDS_PER_FRAME - 1);
    localparam logic [4:0]  GRP_MAX = 5'(GROUPS - 1);
    typedef enum logic [1:0] {IDLE, FETCH, LOAD, RUN} state_t;
    state_t state, state_nxt;
    logic [11:0] shreg;
    logic [3:0]  bit_cnt;
    logic [7:0]  div_cnt;
    logic        fetch_zero, word_zero, in_run, div_end, word_end;
    always_comb begin
        in_run     = state == RUN;
        div_end    = div_cnt == DIV_MAX;
        word_end   = in_run && bit_cnt == 4'd11 && div_end;
        state_nxt  = state;
        case (state)
            IDLE:    state_nxt = enable ? FETCH : IDLE;
            FETCH:   state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     state_nxt = (word_end && !enable) ? IDLE : RUN;
            default: state_nxt = IDLE;
        endcase
        bufGetWord = state == FETCH || (in_run && bit_cnt == 4'd11 && div_cnt == '0);
        bitStrobe  = in_run && div_cnt == '0;
        serOut     = in_run && shreg[11];
        frameStart = in_run && word_zero && bit_cnt == '0 && div_cnt == '0;
        groupStart = frameStart && cntGrp == '0;
        busy       = state != IDLE;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    // Leaving RUN rolls the pointer (and group, across a wrap) back so the prefetched word is refetched
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bufRdPointer <= '0;
            cntGrp       <= '0;
            shreg        <= '0;
            bit_cnt      <= '0;
            div_cnt      <= '0;
            fetch_zero   <= 1'b0;
            word_zero    <= 1'b0;
        end else begin
            if (bufGetWord) begin
                fetch_zero   <= bufRdPointer == '0;
                bufRdPointer <= bufRdPointer == PTR_MAX ? '0 : bufRdPointer + 11'd1;
                if (bufRdPointer == PTR_MAX)
                    cntGrp <= cntGrp == GRP_MAX ? '0 : cntGrp + 5'd1;
            end else if (word_end && !enable) begin
                bufRdPointer <= bufRdPointer == '0 ? PTR_MAX : bufRdPointer - 11'd1;
                if (bufRdPointer == '0)
                    cntGrp <= cntGrp == '0 ? GRP_MAX : cntGrp - 5'd1;
            end
            if (state == LOAD || (word_end && enable)) begin
                shreg     <= dataWord;
                bit_cnt   <= '0;
                div_cnt   <= '0;
                word_zero <= fetch_zero;
            end else if (in_run) begin
                if (div_end) begin
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + 4'd1;
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_m16_frame_sequencer.sv
// tb_m16_frame_sequencer: directed bench with a behavioural filler, small frame/group sizes for fast wraps
module tb_m16_frame_sequencer;
    logic        clk, reset, enable;
    logic [11:0] dataWord;
    logic        bufGetWord, serOut, bitStrobe, frameStart, groupStart, busy;
    logic [10:0] bufRdPointer;
    logic [4:0]  cntGrp;
    int          errors = 0, checks = 0;

    m16_frame_sequencer #(.CLK_PER_BIT(4), .WORDS_PER_FRAME(4), .GROUPS(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .dataWord(dataWord),
        .bufGetWord(bufGetWord), .bufRdPointer(bufRdPointer), .cntGrp(cntGrp),
        .serOut(serOut), .bitStrobe(bitStrobe), .frameStart(frameStart),
        .groupStart(groupStart), .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [11:0] word_of(input logic [10:0] a);
        return a == 0 ? 12'hA5C : 12'h3C6 ^ {a[5:0], a[5:0]};
    endfunction

    always @(posedge clk)
        if (bufGetWord) dataWord <= word_of(bufRdPointer);
        else if (!reset) dataWord <= 12'($urandom);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {10'd0, bufGetWord, serOut, bitStrobe, frameStart, groupStart, busy, bufRdPointer, cntGrp};
    endfunction

    task automatic run_word(input logic [11:0] w, input logic [10:0] nxt, input logic fs, input logic gs);
        for (int b = 0; b < 12; b++)
            for (int c = 0; c < 4; c++) begin
                check("ser", serOut, w[11-b]);
                check("bit_strobe", bitStrobe, c == 0);
                check("fetch_strobe", bufGetWord, b == 11 && c == 0);
                check("busy", busy, 1);
                if (b == 0 && c == 0) begin
                    check("frame_start", frameStart, fs);
                    check("group_start", groupStart, gs);
                end else check("frame_idle", frameStart, 0);
                if (b == 11 && c == 0) check("fetch_ptr", bufRdPointer, nxt);
                tick();
            end
    endtask

    task automatic wait_fetch(input logic [10:0] a, input logic [4:0] g);
        int n = 0;
        while (!(bufGetWord && bufRdPointer == a && cntGrp == g) && n < 4000) begin
            tick();
            n++;
        end
        check("wait_fetch_timeout", n < 4000, 1);
    endtask

    initial begin
        logic [11:0] w;
        reset = 0;
        enable = 0;
        dataWord = '0;
        for (int i = 0; i < 5; i++) begin
            enable = 1'($urandom);
            tick();
            check("reset_outs", outs(), 0);
        end
        reset = 1;
        enable = 0;
        repeat (3) tick();
        check("idle_outs", outs(), 0);
        // startup
        enable = 1;
        tick();
        check("start_strobe", bufGetWord, 1);
        check("start_ptr", bufRdPointer, 0);
        tick();
        check("load_strobe", bufGetWord, 0);
        check("load_ptr", bufRdPointer, 1);
        check("load_ser", serOut, 0);
        tick();
        run_word(12'hA5C, 1, 1, 1);
        run_word(word_of(1), 2, 0, 0);
        run_word(word_of(2), 3, 0, 0);
        run_word(word_of(3), 0, 0, 0);
        check("grp_after_wrap", cntGrp, 1);
        run_word(word_of(0), 1, 1, 0);
        // frame wrap into group 5
        wait_fetch(3, 4);
        tick();
        check("wrap5_ptr", bufRdPointer, 0);
        check("wrap5_grp", cntGrp, 5);
        repeat (3) tick();
        run_word(word_of(3), 0, 0, 0);
        run_word(word_of(0), 1, 1, 0);
        // group wrap 7 -> 0
        wait_fetch(3, 7);
        tick();
        check("wrap0_ptr", bufRdPointer, 0);
        check("wrap0_grp", cntGrp, 0);
        repeat (3) tick();
        run_word(word_of(3), 0, 0, 0);
        run_word(word_of(0), 1, 1, 1);
        // disable at bit 3 of word 1
        w = word_of(1);
        for (int i = 0; i < 48; i++) begin
            if (i == 12) enable = 0;
            check("drain_ser", serOut, w[11 - i/4]);
            check("drain_busy", busy, 1);
            tick();
        end
        check("stop_busy", busy, 0);
        check("stop_ser", serOut, 0);
        check("rollback_ptr", bufRdPointer, 2);
        repeat (3) tick();
        check("idle_strobe", bufGetWord, 0);
        enable = 1;
        tick();
        check("refetch_strobe", bufGetWord, 1);
        check("refetch_ptr", bufRdPointer, 2);
        repeat (2) tick();
        run_word(word_of(2), 3, 0, 0);
        // async reset at bit 7 of word 3
        repeat (28) tick();
        check("pre_reset_busy", busy, 1);
        #2 reset = 0;
        #1 check("async_reset_outs", outs(), 0);
        tick();
        check("held_reset_outs", outs(), 0);
        reset = 1;
        tick();
        check("restart_strobe", bufGetWord, 1);
        check("restart_ptr", bufRdPointer, 0);
        repeat (2) tick();
        run_word(12'hA5C, 1, 1, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/m16_frame_sequencer.md
Name: m16_frame_sequencer

Overview:
- Sequences the M16 telemetry word filler: walks the buffer read pointer through the frame, issues one-clock fetch strobes, and advances the group counter on each frame wrap.
- Captures each 12-bit filler word and serialises it MSB-first as a continuous bit stream with frame and group markers.
- Sits between the filler and the line driver; it is the only source of the filler's read strobe, pointer and group number.

Parameters:
- CLK_PER_BIT, 4, clocks per serial bit; legal range 2..255; minimum 2 guarantees the fetched word is valid before load.
- WORDS_PER_FRAME, 2048, words per frame; pointer wraps at WORDS_PER_FRAME-1.
- GROUPS, 32, frames per group; cntGrp wraps at GROUPS-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run request, level-sensitive.
- dataWord  in  12  filler output; registered by the filler on the edge that samples bufGetWord.
- bufGetWord  out  1  one-clock fetch strobe to the filler.
- bufRdPointer  out  11  address of the word being fetched.
- cntGrp  out  5  current frame-in-group index.
- serOut  out  1  serial data, MSB first.
- bitStrobe  out  1  one-clock pulse on the first clock of every bit.
- frameStart  out  1  one-clock pulse when word 0 of a frame begins shifting.
- groupStart  out  1  like frameStart, but only when cntGrp==0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, asynchronous: state=IDLE; bufRdPointer=0; cntGrp=0; shift register=0; bit and divider counters=0; all outputs 0.
- States and transitions: IDLE -> FETCH -> LOAD -> RUN -> (IDLE at a word boundary if enable=0).
- IDLE: serOut=0, busy=0. If enable=1 at an edge, go to FETCH.
- FETCH (1 clk): bufGetWord=1 with the current bufRdPointer. Next edge: go to LOAD, advance the pointer.
- LOAD (1 clk): at the edge, shreg<=dataWord, bitCnt=0, divCnt=0, go to RUN.
- Latency: enable sampled at edge E0 -> strobe during E0..E1 -> first bit on serOut from E2.
- RUN, divider: divCnt counts 0..CLK_PER_BIT-1. bitStrobe=1 when divCnt==0. At divCnt==CLK_PER_BIT-1, shift left and increment bitCnt (0..11).
- RUN, output: serOut = shreg[11] throughout.
- RUN, prefetch: when bitCnt==11 and divCnt==0, assert bufGetWord for exactly 1 clk with the next address; the pointer advances on the following edge.
- RUN, word boundary: at the edge ending bitCnt==11, divCnt==CLK_PER_BIT-1:
  - if enable=1, shreg<=dataWord and bitCnt=0 (no gap between words);
  - if enable=0, go to IDLE.
  - enable is sampled only at this boundary; deasserting it mid-word completes the word.
- Word period: 12*CLK_PER_BIT clocks, exactly one strobe per word.
- Pointer advance: +1 on the edge after every strobe.
  - At WORDS_PER_FRAME-1 it wraps to 0, and cntGrp increments in the same edge.
  - cntGrp wraps GROUPS-1 -> 0.
- Markers:
  - A flag records whether the fetched address was 0.
  - frameStart pulses for 1 clk in the first clock of the loaded word when that flag is set.
  - groupStart additionally requires cntGrp==0 at that point.
- Resume: bufRdPointer and cntGrp are preserved through IDLE. Restart resumes at the next unfetched address, and the prefetched-but-unsent word is refetched (the pointer is rolled back by 1 on entry to IDLE).
- Reset mid-operation: immediate return to reset values with no partial strobe; serOut=0 in the same cycle.
- Simultaneous events: a wrap and a group increment at the same edge are both applied. enable rising in the same clock as reset deassertion is ignored until the next edge.

Test Plan:
- Reset: hold reset=0 with random enable and dataWord -> all outputs 0 and busy=0; release -> remains IDLE while enable=0.
- Startup, CLK_PER_BIT=4, filler returns 0xA5C for address 0:
  - enable at E0 -> bufGetWord high for exactly 1 clk with pointer 0;
  - serOut from E2 shows 1,0,1,0,0,1,0,1,1,1,0,0, each bit held 4 clks;
  - frameStart and groupStart pulse at E2.
- Prefetch timing: across 3 words -> strobe occurs 1 per 48 clks, in the first clock of bit 11; pointer sequence 0,1,2,3; serial stream has no gaps.
- Wrap, starting at pointer 2047 and cntGrp 31:
  - after the strobe, pointer=0 and cntGrp=0;
  - the next word load gives frameStart=1 and groupStart=1;
  - with cntGrp=5 instead, frameStart=1 and groupStart=0.
- Disable mid-word at bit 3 -> word completes all 12 bits, then IDLE; pointer is rolled back. Re-enable -> the same address is refetched first.
- Async reset asserted at bit 7 -> outputs 0 in the same cycle; restart fetches address 0.
